// File: rtl/bloco_controle_pkg.sv
// Shared constants for the polynomial controller and its datapath:
// state encoding, mux select codes and ULA op codes.
package bloco_controle_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        MUL1,
        SOMA1,
        MUL2,
        SOMA2,
        FIM
    } estado_t;

    localparam logic [1:0] M0_ZERO = 2'b00;
    localparam logic [1:0] M0_A    = 2'b01;
    localparam logic [1:0] M0_B    = 2'b10;
    localparam logic [1:0] M0_C    = 2'b11;

    localparam logic [1:0] M1_M0   = 2'b00;
    localparam logic [1:0] M1_X    = 2'b01;
    localparam logic [1:0] M1_S    = 2'b10;
    localparam logic [1:0] M1_H    = 2'b11;

    localparam logic [1:0] M2_X    = 2'b00;
    localparam logic [1:0] M2_M0   = 2'b01;
    localparam logic [1:0] M2_S    = 2'b10;
    localparam logic [1:0] M2_H    = 2'b11;

    localparam logic SOMA = 1'b0;
    localparam logic MULT = 1'b1;

    typedef struct packed {
        logic       lx;
        logic [1:0] selecaoM0;
        logic [1:0] selecaoM1;
        logic [1:0] selecaoM2;
        logic       h;
        logic       ls;
        logic       lh;
        logic       ocupado;
        logic       pronto;
    } controle_t;

endpackage

// File: rtl/bloco_controle_contador_operacoes.sv
// Completed-operation counter, 8 bits, wraps 255 -> 0.
module contador_operacoes (
    input  logic       clock,
    input  logic       reset,
    input  logic       incrementa,
    output logic [7:0] contagem
);

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem <= 8'd0;
        end else if (incrementa) begin
            contagem <= contagem + 8'd1;
        end
    end

endmodule

// File: rtl/bloco_controle.sv
// Moore controller sequencing the datapath through a*x^2+b*x+c
// (modo=0) or a*x+b (modo=1).
module bloco_controle
    import bloco_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       modo,
    output logic       lx,
    output logic [1:0] selecaoM0,
    output logic [1:0] selecaoM1,
    output logic [1:0] selecaoM2,
    output logic       h,
    output logic       ls,
    output logic       lh,
    output logic       ocupado,
    output logic       pronto,
    output logic [7:0] contagem
);

    estado_t   estado;
    estado_t   proximo;
    logic      modoLatched;
    controle_t ctrl;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= OCIOSO;
            modoLatched <= 1'b0;
        end else begin
            estado <= proximo;
            if (estado == OCIOSO && iniciar) begin
                modoLatched <= modo;
            end
        end
    end

    always_comb begin
        ctrl    = '0;
        proximo = estado;
        case (estado)
            OCIOSO: begin
                if (iniciar) proximo = CARREGA;
            end
            CARREGA: begin
                // 0+0 through the ULA clears S and H while X loads
                ctrl.lx        = 1'b1;
                ctrl.selecaoM0 = M0_ZERO;
                ctrl.selecaoM1 = M1_M0;
                ctrl.selecaoM2 = M2_M0;
                ctrl.h         = SOMA;
                ctrl.ls        = 1'b1;
                ctrl.lh        = 1'b1;
                ctrl.ocupado   = 1'b1;
                proximo        = MUL1;
            end
            MUL1: begin
                ctrl.selecaoM0 = M0_A;
                ctrl.selecaoM1 = M1_M0;
                ctrl.selecaoM2 = M2_X;
                ctrl.h         = MULT;
                ctrl.ls        = 1'b1;
                ctrl.ocupado   = 1'b1;
                proximo        = SOMA1;
            end
            SOMA1: begin
                ctrl.selecaoM0 = M0_B;
                ctrl.selecaoM1 = M1_S;
                ctrl.selecaoM2 = M2_M0;
                ctrl.h         = SOMA;
                ctrl.ls        = 1'b1;
                ctrl.ocupado   = 1'b1;
                proximo        = modoLatched ? FIM : MUL2;
            end
            MUL2: begin
                ctrl.selecaoM0 = M0_ZERO;
                ctrl.selecaoM1 = M1_S;
                ctrl.selecaoM2 = M2_X;
                ctrl.h         = MULT;
                ctrl.ls        = 1'b1;
                ctrl.ocupado   = 1'b1;
                proximo        = SOMA2;
            end
            SOMA2: begin
                ctrl.selecaoM0 = M0_C;
                ctrl.selecaoM1 = M1_S;
                ctrl.selecaoM2 = M2_M0;
                ctrl.h         = SOMA;
                ctrl.ls        = 1'b1;
                ctrl.lh        = 1'b1;
                ctrl.ocupado   = 1'b1;
                proximo        = FIM;
            end
            FIM: begin
                ctrl.pronto  = 1'b1;
                ctrl.ocupado = 1'b1;
                proximo      = OCIOSO;
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    assign lx        = ctrl.lx;
    assign selecaoM0 = ctrl.selecaoM0;
    assign selecaoM1 = ctrl.selecaoM1;
    assign selecaoM2 = ctrl.selecaoM2;
    assign h         = ctrl.h;
    assign ls        = ctrl.ls;
    assign lh        = ctrl.lh;
    assign ocupado   = ctrl.ocupado;
    assign pronto    = ctrl.pronto;

    contador_operacoes uContador (
        .clock      (clock),
        .reset      (reset),
        .incrementa (estado == FIM),
        .contagem   (contagem)
    );

endmodule

// File: tb/tb_bloco_controle.sv
// Directed bench: controller driving a behavioural 16-bit datapath.
module tb_bloco_controle;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic        modo;
    logic        lx;
    logic [1:0]  selecaoM0;
    logic [1:0]  selecaoM1;
    logic [1:0]  selecaoM2;
    logic        h;
    logic        ls;
    logic        lh;
    logic        ocupado;
    logic        pronto;
    logic [7:0]  contagem;

    logic [15:0] a, b, c, xIn;
    logic [15:0] regX, regS, regH;
    logic [15:0] m0v, opA, opB, ula;
    logic [15:0] resultado;
    logic        sawMul2, sawSoma2;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    bloco_controle dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .modo      (modo),
        .lx        (lx),
        .selecaoM0 (selecaoM0),
        .selecaoM1 (selecaoM1),
        .selecaoM2 (selecaoM2),
        .h         (h),
        .ls        (ls),
        .lh        (lh),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .contagem  (contagem)
    );

    always_comb begin
        case (selecaoM0)
            2'b00:   m0v = 16'd0;
            2'b01:   m0v = a;
            2'b10:   m0v = b;
            default: m0v = c;
        endcase
        case (selecaoM1)
            2'b00:   opA = m0v;
            2'b01:   opA = regX;
            2'b10:   opA = regS;
            default: opA = regH;
        endcase
        case (selecaoM2)
            2'b00:   opB = regX;
            2'b01:   opB = m0v;
            2'b10:   opB = regS;
            default: opB = regH;
        endcase
        ula = h ? opA * opB : opA + opB;
    end

    always @(posedge clock) begin
        if (reset) begin
            regX <= 16'd0;
            regS <= 16'd0;
            regH <= 16'd0;
        end else begin
            if (lx) regX <= xIn;
            if (ls) regS <= ula;
            if (lh) regH <= ula;
        end
    end

    assign resultado = regS;

    always @(negedge clock) begin
        if (h && selecaoM1 == 2'b10 && selecaoM2 == 2'b00) sawMul2 = 1'b1;
        if (lh && selecaoM0 == 2'b11) sawSoma2 = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic waitPronto(output int n);
        n = 0;
        while (!pronto && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic startOp(input logic [15:0] va, vb, vc, vx,
                           input logic m);
        a = va; b = vb; c = vc; xIn = vx;
        modo = m;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        modo = ~m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        iniciar = 1'b1;
        modo = 1'b0;
        tick();
        tick();
        compared++;
        if ({lx, selecaoM0, selecaoM1, selecaoM2, h, ls, lh,
             ocupado, pronto, contagem} !== 19'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got ocupado=%b contagem=%0d want all 0",
                     ocupado, contagem);
        end
        reset = 1'b0;
        iniciar = 1'b0;
        tick();
        compared++;
        if (ocupado !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got ocupado=%b want 0", ocupado);
        end
    endtask

    task automatic test_quadratic();
        int n;
        startOp(16'd2, 16'd3, 16'd4, 16'd5, 1'b0);
        compared++;
        if ({lx, selecaoM0, selecaoM1, selecaoM2, h, ls, lh, ocupado}
            !== 11'b1_00_00_01_0_1_1_1) begin
            mismatched++;
            $display("FAIL carrega_outputs: got lx=%b m0=%b m1=%b m2=%b h=%b ls=%b lh=%b",
                     lx, selecaoM0, selecaoM1, selecaoM2, h, ls, lh);
        end
        waitPronto(n);
        compared++;
        if (n !== 5) begin
            mismatched++;
            $display("FAIL quad_latency: got %0d want 5", n);
        end
        compared++;
        if (resultado !== 16'd69) begin
            mismatched++;
            $display("FAIL quad_result: got %0d want 69", resultado);
        end
        compared++;
        if (contagem !== 8'd0) begin
            mismatched++;
            $display("FAIL quad_count_in_fim: got %0d want 0", contagem);
        end
        tick();
        compared++;
        if (contagem !== 8'd1 || ocupado !== 1'b0 || pronto !== 1'b0) begin
            mismatched++;
            $display("FAIL quad_after: got contagem=%0d ocupado=%b pronto=%b want 1 0 0",
                     contagem, ocupado, pronto);
        end
    endtask

    task automatic test_linear();
        int n;
        sawMul2 = 1'b0;
        sawSoma2 = 1'b0;
        startOp(16'd2, 16'd3, 16'd4, 16'd5, 1'b1);
        waitPronto(n);
        compared++;
        if (n !== 3) begin
            mismatched++;
            $display("FAIL lin_latency: got %0d want 3", n);
        end
        compared++;
        if (resultado !== 16'd13) begin
            mismatched++;
            $display("FAIL lin_result: got %0d want 13", resultado);
        end
        compared++;
        if (sawMul2 !== 1'b0 || sawSoma2 !== 1'b0) begin
            mismatched++;
            $display("FAIL lin_states: got mul2=%b soma2=%b want 0 0",
                     sawMul2, sawSoma2);
        end
        tick();
        compared++;
        if (contagem !== 8'd2) begin
            mismatched++;
            $display("FAIL lin_count: got %0d want 2", contagem);
        end
    endtask

    task automatic test_overflow();
        int n;
        startOp(16'hFFFF, 16'd0, 16'd0, 16'd2, 1'b0);
        waitPronto(n);
        compared++;
        if (n !== 5 || resultado !== 16'hFFFC) begin
            mismatched++;
            $display("FAIL overflow: got n=%0d res=%h want n=5 res=fffc",
                     n, resultado);
        end
        tick();
        compared++;
        if (contagem !== 8'd3) begin
            mismatched++;
            $display("FAIL overflow_count: got %0d want 3", contagem);
        end
    endtask

    task automatic test_reset_mid();
        logic sawPronto;
        startOp(16'd2, 16'd3, 16'd4, 16'd5, 1'b0);
        tick();
        tick();
        tick();
        compared++;
        if (h !== 1'b1 || selecaoM1 !== 2'b10 || selecaoM2 !== 2'b00) begin
            mismatched++;
            $display("FAIL mid_in_mul2: got h=%b m1=%b m2=%b want 1 10 00",
                     h, selecaoM1, selecaoM2);
        end
        reset = 1'b1;
        iniciar = 1'b1;
        tick();
        compared++;
        if ({lx, selecaoM0, selecaoM1, selecaoM2, h, ls, lh,
             ocupado, pronto, contagem} !== 19'd0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: got ocupado=%b pronto=%b contagem=%0d want 0",
                     ocupado, pronto, contagem);
        end
        reset = 1'b0;
        iniciar = 1'b0;
        sawPronto = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pronto) sawPronto = 1'b1;
            tick();
        end
        compared++;
        if (sawPronto !== 1'b0 || contagem !== 8'd0 || ocupado !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_abort: got pronto_seen=%b contagem=%0d ocupado=%b want 0 0 0",
                     sawPronto, contagem, ocupado);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic m;
        logic mNext;
        a = 16'd2; b = 16'd3; c = 16'd4; xIn = 16'd5;
        m = 1'b0;
        modo = m;
        iniciar = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (!pronto && n < 20) begin
                modo = ~modo;
                tick();
                n++;
            end
            compared++;
            if (n !== (m ? 3 : 5) || resultado !== (m ? 16'd13 : 16'd69)) begin
                mismatched++;
                $display("FAIL b2b_op%0d: got n=%0d res=%0d want n=%0d res=%0d",
                         i, n, resultado, m ? 3 : 5, m ? 13 : 69);
            end
            compared++;
            if (contagem !== 8'(i)) begin
                mismatched++;
                $display("FAIL b2b_count_fim%0d: got %0d want %0d",
                         i, contagem, i % 256);
            end
            mNext = (i % 3 == 1);
            modo = mNext;
            if (i == 255) iniciar = 1'b0;
            tick();
            compared++;
            if (ocupado !== 1'b0 || contagem !== 8'((i + 1) % 256)) begin
                mismatched++;
                $display("FAIL b2b_idle%0d: got ocupado=%b contagem=%0d want 0 %0d",
                         i, ocupado, contagem, (i + 1) % 256);
            end
            tick();
            m = mNext;
        end
        compared++;
        if (contagem !== 8'd0 || ocupado !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_wrap: got contagem=%0d ocupado=%b want 0 0",
                     contagem, ocupado);
        end
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        modo = 1'b0;
        a = 16'd0; b = 16'd0; c = 16'd0; xIn = 16'd0;
        sawMul2 = 1'b0;
        sawSoma2 = 1'b0;
        @(negedge clock);
        test_reset();
        test_quadratic();
        test_linear();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
